// File: rtl/param_queue.sv
// Parametrised synchronous FIFO with occupancy count and almost-full/empty flags.
// Define QUEUE_ERR_FLAGS_EN to enable sticky overflow/underflow flags; otherwise they read 0.
module param_queue #(
  parameter int WIDTH         = 8,
  parameter int DEPTH_LOG2    = 4,
  parameter int AFULL_THRESH  = (2**DEPTH_LOG2) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enqueue,
  input  logic                  dequeue,
  input  logic [WIDTH-1:0]      in,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic [DEPTH_LOG2-1:0] Fp,
  output logic [DEPTH_LOG2-1:0] Bp,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_C  = (DEPTH_LOG2+1)'(AFULL_THRESH);
  localparam logic [DEPTH_LOG2:0] AEMPTY_C = (DEPTH_LOG2+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] fp_reg, fp_next;
  logic [DEPTH_LOG2-1:0] bp_reg, bp_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic [WIDTH-1:0]      out_reg;
  logic                  out_valid_reg;
  logic                  deq_ok, enq_ok;

  // A dequeue in the same cycle frees a slot, so a full queue still accepts a write.
  always_comb begin
    deq_ok     = dequeue && (count_reg != '0);
    enq_ok     = enqueue && ((count_reg != DEPTH_C) || deq_ok);
    fp_next    = deq_ok ? fp_reg + DEPTH_LOG2'(1) : fp_reg;
    bp_next    = enq_ok ? bp_reg + DEPTH_LOG2'(1) : bp_reg;
    count_next = count_reg;
    case ({enq_ok, deq_ok})
      2'b10:   count_next = count_reg + (DEPTH_LOG2+1)'(1);
      2'b01:   count_next = count_reg - (DEPTH_LOG2+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n && enq_ok) begin
      mem[bp_reg] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fp_reg        <= '0;
      bp_reg        <= '0;
      count_reg     <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      fp_reg        <= fp_next;
      bp_reg        <= bp_next;
      count_reg     <= count_next;
      out_valid_reg <= deq_ok;
      if (deq_ok) begin
        out_reg <= mem[fp_reg];
      end
    end
  end

`ifdef QUEUE_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (enqueue && !enq_ok) overflow_reg  <= 1'b1;
      if (dequeue && !deq_ok) underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign out          = out_reg;
  assign out_valid    = out_valid_reg;
  assign Fp           = fp_reg;
  assign Bp           = bp_reg;
  assign count        = count_reg;
  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AFULL_C);
  assign almost_empty = (count_reg <= AEMPTY_C);

endmodule

// File: tb/tb_param_queue.sv
// Randomised and directed bench for param_queue, checked against a queue-based model.
// Honours QUEUE_ERR_FLAGS_EN the same way the design does.
module tb_param_queue;

  localparam int WIDTH  = 8;
  localparam int DLOG2  = 2;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;
  localparam int AEMPTY = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enqueue = 1'b0;
  logic             dequeue = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic [DLOG2-1:0] fp, bp;
  logic [DLOG2:0]   count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] out_m = '0;
  bit               ov_m = 0, ovf_m = 0, unf_m = 0;
  int               fp_m = 0, bp_m = 0;

  param_queue #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DLOG2), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enqueue(enqueue), .dequeue(dequeue), .in(din),
    .out(dout), .out_valid(out_valid), .Fp(fp), .Bp(bp), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, compare every output just after the edge.
  task automatic step(input bit e, input bit d, input logic [WIDTH-1:0] data, input bit rn);
    bit deq_ok, enq_ok;
    enqueue = e; dequeue = d; din = data; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      out_m = '0; ov_m = 0; ovf_m = 0; unf_m = 0; fp_m = 0; bp_m = 0;
    end else begin
      deq_ok = d && (q.size() > 0);
      enq_ok = e && (q.size() < DEPTH || deq_ok);
      ov_m = deq_ok;
      if (deq_ok) begin
        out_m = q.pop_front();
        fp_m = (fp_m + 1) % DEPTH;
      end
      if (enq_ok) begin
        q.push_back(data);
        bp_m = (bp_m + 1) % DEPTH;
      end
`ifdef QUEUE_ERR_FLAGS_EN
      if (e && !enq_ok) ovf_m = 1;
      if (d && !deq_ok) unf_m = 1;
`endif
    end
    #1;
    check("out",          32'(dout),         32'(out_m));
    check("out_valid",    32'(out_valid),    32'(ov_m));
    check("count",        32'(count),        32'(q.size()));
    check("full",         32'(full),         32'(q.size() == DEPTH));
    check("empty",        32'(empty),        32'(q.size() == 0));
    check("almost_full",  32'(almost_full),  32'(q.size() >= AFULL));
    check("almost_empty", 32'(almost_empty), 32'(q.size() <= AEMPTY));
    check("Fp",           32'(fp),           32'(fp_m));
    check("Bp",           32'(bp),           32'(bp_m));
    check("overflow",     32'(overflow),     32'(ovf_m));
    check("underflow",    32'(underflow),    32'(unf_m));
    $display("[TB] t=%0t rst_n=%0b enq=%0b deq=%0b in=%02h -> out=%02h v=%0b count=%0d",
             $time, rn, e, d, data, dout, out_valid, count);
  endtask

  initial begin
    logic [WIDTH-1:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);

    // Fill to full, then overflow attempt
    for (int i = 0; i < 4; i++) step(1, 0, fill[i], 1);
    check("fill_bp_wrap", 32'(bp), 32'd0);
    step(1, 0, 8'h55, 1);

    // Drain in order, then underflow attempt
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h00, 1);
      check("drain_data", 32'(dout), 32'(fill[i]));
    end
    step(0, 1, 8'h00, 1);

    // Simultaneous ops on full
    for (int i = 0; i < 4; i++) step(1, 0, fill[i], 1);
    step(1, 1, 8'h66, 1);
    check("full_both_out", 32'(dout), 32'h11);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 1);
    check("full_both_last", 32'(dout), 32'h66);

    // Simultaneous ops on empty
    step(1, 1, 8'h77, 1);
    check("empty_both_cnt", 32'(count), 32'd1);
    step(0, 1, 8'h00, 1);

    // Interleaved wrap-around
    for (int i = 0; i < 10; i++) step(1, (i % 3) != 0, 8'(8'h80 + i), 1);
    while (q.size() > 0) step(0, 1, 8'h00, 1);

    // Mid-operation reset with enqueue held high
    for (int i = 0; i < 3; i++) step(1, 0, fill[i], 1);
    step(1, 0, 8'hee, 0);
    check("midrst_count", 32'(count), 32'd0);
    step(1, 0, 8'h5a, 1);
    step(0, 1, 8'h00, 1);
    check("midrst_data", 32'(dout), 32'h5a);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), ($urandom_range(0, 49) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
